alu_mdu_responder: RTL and testbench

- Sequential 32-bit ALU responder; serves operation requests from the datapath controller using a start/busy/done handshake.
- Single-cycle ops (add, sub, logic, shift, rotate, neg, not) use the same handshake as multi-cycle signed multiply and divide.
- Produces a 64-bit result split into HI/LO for the CPU's HI/LO and Z registers.

---
 rtl/alu_mdu_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_mdu_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_responder.sv
// Sequential 32-bit ALU responder with start/busy/done handshake, iterative signed MUL and DIV.
// Optional macro MUL_RADIX4_EN selects radix-4 Booth multiplication (16 iterations) instead of radix-2.
module alu_mdu_responder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(WIDTH) + 1;
  localparam int unsigned ACCW = 2 * WIDTH;
`ifdef MUL_RADIX4_EN
  localparam int unsigned MUL_ITERS = WIDTH / 2;
`else
  localparam int unsigned MUL_ITERS = WIDTH;
`endif
  localparam int unsigned DIV_ITERS = WIDTH;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(6);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(7);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(8);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(9);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(10);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(11);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(12);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              busy_d, done_d, load_res;
  logic              accept;

  logic [OPW-1:0]    op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0]   acc_q;

  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              neg_prod;
  logic [ACCW-1:0]   mul_next;
  logic [ACCW-1:0]   div_next;
  logic [WIDTH-1:0]  res_lo_c, res_hi_c;

  assign accept   = (state_q == S_IDLE) && start;
  assign mag_a    = a_q[WIDTH-1] ? -a_q : a_q;
  assign mag_b    = b_q[WIDTH-1] ? -b_q : b_q;
  assign neg_prod = a_q[WIDTH-1] ^ b_q[WIDTH-1];

  // State register plus registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL)                         state_d = S_MUL;
          else if (op == OP_DIV && in_b != '0)      state_d = S_DIV;
          else                                      state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (cnt_q == CNTW'(MUL_ITERS)) state_d = S_DONE;
      S_DIV:  if (cnt_q == CNTW'(DIV_ITERS)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered one cycle later alongside the state
  always_comb begin
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load_res = 1'b0;
    if (state_d inside {S_EXEC, S_MUL, S_DIV, S_FIX}) busy_d = 1'b1;
    if (state_d == S_DONE) begin
      done_d   = 1'b1;
      load_res = 1'b1;
    end
  end

  // Counter value 0 is a setup cycle; iterations run on 1..N
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_MUL || state_q == S_DIV) && state_d == state_q)
      cnt_d = cnt_q + CNTW'(1);
  end

`ifdef MUL_RADIX4_EN
  logic [ACCW-1:0]  mc_q;
  logic [WIDTH:0]   mq_q;
  logic [ACCW-1:0]  booth_pp;

  // Booth radix-4 partial product select from the current multiplier triplet
  always_comb begin
    booth_pp = '0;
    case (mq_q[2:0])
      3'b001, 3'b010: booth_pp = mc_q;
      3'b011:         booth_pp = mc_q << 1;
      3'b100:         booth_pp = -(mc_q << 1);
      3'b101, 3'b110: booth_pp = -mc_q;
      default:        booth_pp = '0;
    endcase
  end

  assign mul_next = acc_q + booth_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_q <= '0;
      mq_q <= '0;
    end else if (state_q == S_MUL) begin
      if (cnt_q == '0) begin
        mc_q <= ACCW'($signed(a_q));
        mq_q <= {b_q, 1'b0};
      end else begin
        mc_q <= mc_q << 2;
        mq_q <= {{2{mq_q[WIDTH]}}, mq_q[WIDTH:2]};
      end
    end
  end
`else
  logic [WIDTH:0]   mul_sum;
  logic [ACCW-1:0]  mul_step;

  // Shift-add on magnitudes; sign applied by negation on the last iteration
  always_comb begin
    mul_sum  = {1'b0, acc_q[ACCW-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    mul_next = mul_step;
    if (cnt_q == CNTW'(MUL_ITERS) && neg_prod) mul_next = -mul_step;
  end
`endif

  // Restoring division step: acc holds {remainder, dividend/quotient}
  logic [WIDTH:0] rem_sh, div_diff;
  logic           div_ge;
  always_comb begin
    rem_sh   = {acc_q[ACCW-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, mag_b};
    div_ge   = rem_sh >= {1'b0, mag_b};
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

  logic [WIDTH:0]      add_w, sub_w;
  logic [ACCW-1:0]     rot_r, rot_l;
  logic [SHW-1:0]      amt;
  logic [WIDTH-1:0]    quo, rem;

  assign amt   = b_q[SHW-1:0];
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  assign rot_r = {a_q, a_q} >> amt;
  assign rot_l = {a_q, a_q} << amt;
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[ACCW-1:WIDTH];

  // Result selection for the state that transitions into DONE
  always_comb begin
    res_lo_c = '0;
    res_hi_c = '0;
    case (state_q)
      S_EXEC: begin
        case (op_q)
          OP_ADD:  begin res_lo_c = add_w[WIDTH-1:0]; res_hi_c = WIDTH'(add_w[WIDTH]); end
          OP_SUB:  begin res_lo_c = sub_w[WIDTH-1:0]; res_hi_c = WIDTH'(sub_w[WIDTH]); end
          OP_AND:  res_lo_c = a_q & b_q;
          OP_OR:   res_lo_c = a_q | b_q;
          OP_SHR:  res_lo_c = a_q >> amt;
          OP_SHRA: res_lo_c = $signed(a_q) >>> amt;
          OP_SHL:  res_lo_c = a_q << amt;
          OP_ROR:  res_lo_c = rot_r[WIDTH-1:0];
          OP_ROL:  res_lo_c = rot_l[ACCW-1:WIDTH];
          OP_NEG:  res_lo_c = -a_q;
          OP_NOT:  res_lo_c = ~a_q;
          OP_DIV:  begin res_lo_c = '1; res_hi_c = a_q; end
          default: begin res_lo_c = '0; res_hi_c = '0; end
        endcase
      end
      S_MUL: begin
        res_lo_c = mul_next[WIDTH-1:0];
        res_hi_c = mul_next[ACCW-1:WIDTH];
      end
      S_FIX: begin
        res_lo_c = neg_prod     ? -quo : quo;
        res_hi_c = a_q[WIDTH-1] ? -rem : rem;
      end
      default: begin
        res_lo_c = '0;
        res_hi_c = '0;
      end
    endcase
  end

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      cnt_q <= cnt_d;
      if (state_q == S_MUL) begin
        if (cnt_q == '0) begin
`ifdef MUL_RADIX4_EN
          acc_q <= '0;
`else
          acc_q <= ACCW'(mag_b);
`endif
        end else begin
          acc_q <= mul_next;
        end
      end else if (state_q == S_DIV) begin
        if (cnt_q == '0) acc_q <= ACCW'(mag_a);
        else             acc_q <= div_next;
      end
      if (load_res) begin
        result_lo   <= res_lo_c;
        result_hi   <= res_hi_c;
        div_by_zero <= (state_q == S_EXEC) && (op_q == OP_DIV);
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_responder.sv
// Directed self-checking bench for alu_mdu_responder (handshake latency, results, reset abort).
module tb_alu_mdu_responder;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, SHR = 5'd4,
                         SHRA = 5'd5, SHL = 5'd6, ROR = 5'd7, ROL = 5'd8, MUL = 5'd9,
                         DIV = 5'd10, NEG = 5'd11, NOT_ = 5'd12;
`ifdef MUL_RADIX4_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 35;

  logic        clk, rst_n, start;
  logic [4:0]  op;
  logic [31:0] in_a, in_b;
  logic        busy, done, div_by_zero;
  logic [31:0] result_lo, result_hi;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mdu_responder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at cycle 0, wait for done, check latency and results
  task automatic do_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_lo,
                       input logic [31:0] exp_hi, input logic exp_dbz);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; in_a = a; in_b = b;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (n == 1) chk({tag, ".busy1"}, 64'(busy), 64'd1);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".lo"}, 64'(result_lo), 64'(exp_lo));
    chk({tag, ".hi"}, 64'(result_hi), 64'(exp_hi));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat, ndone;
    rst_n = 1'b0; start = 1'b0; op = '0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.lo", 64'(result_lo), 64'd0);
    chk("rst.hi", 64'(result_hi), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    do_op("add_5_2",   ADD,  32'd5,          32'd2,          2, 32'd7,          32'd0, 1'b0);
    do_op("add_carry", ADD,  32'hFFFFFFFF,   32'd1,          2, 32'd0,          32'd1, 1'b0);
    do_op("sub_borrow",SUB,  32'd3,          32'd5,          2, 32'hFFFFFFFE,   32'd1, 1'b0);
    do_op("sub_pos",   SUB,  32'd5,          32'd3,          2, 32'd2,          32'd0, 1'b0);
    do_op("and",       AND_, 32'hF0F01234,   32'h0FF0FF00,   2, 32'h00F01200,   32'd0, 1'b0);
    do_op("or",        OR_,  32'hF0F01234,   32'h0FF0FF00,   2, 32'hFFF0FF34,   32'd0, 1'b0);
    do_op("shr",       SHR,  32'h80000000,   32'd4,          2, 32'h08000000,   32'd0, 1'b0);
    do_op("shl",       SHL,  32'd1,          32'd31,         2, 32'h80000000,   32'd0, 1'b0);
    do_op("shl_amt0",  SHL,  32'h12345678,   32'd32,         2, 32'h12345678,   32'd0, 1'b0);
    do_op("ror",       ROR,  32'h00000001,   32'd1,          2, 32'h80000000,   32'd0, 1'b0);
    do_op("rol_33",    ROL,  32'h80000000,   32'd33,         2, 32'h00000001,   32'd0, 1'b0);
    do_op("neg",       NEG,  32'd5,          32'd0,          2, 32'hFFFFFFFB,   32'd0, 1'b0);
    do_op("not",       NOT_, 32'h00000000,   32'd9,          2, 32'hFFFFFFFF,   32'd0, 1'b0);
    do_op("rsvd13",    5'd13,32'd1,          32'd1,          2, 32'd0,          32'd0, 1'b0);
    do_op("rsvd31",    5'd31,32'hFFFFFFFF,   32'hFFFFFFFF,   2, 32'd0,          32'd0, 1'b0);

    do_op("mul_m3_7",  MUL,  32'hFFFFFFFD,   32'd7,          MUL_LAT, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    do_op("mul_min",   MUL,  32'h80000000,   32'h80000000,   MUL_LAT, 32'h00000000, 32'h40000000, 1'b0);
    do_op("mul_neg1",  MUL,  32'd12345,      32'hFFFFFFFF,   MUL_LAT, 32'hFFFFCFC7, 32'hFFFFFFFF, 1'b0);
    do_op("mul_max",   MUL,  32'h7FFFFFFF,   32'h7FFFFFFF,   MUL_LAT, 32'h00000001, 32'h3FFFFFFF, 1'b0);

    do_op("div_m7_2",  DIV,  32'hFFFFFFF9,   32'd2,          DIV_LAT, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    do_op("div_7_m2",  DIV,  32'd7,          32'hFFFFFFFE,   DIV_LAT, 32'hFFFFFFFD, 32'd1,        1'b0);
    do_op("div_ovf",   DIV,  32'h80000000,   32'hFFFFFFFF,   DIV_LAT, 32'h80000000, 32'd0,        1'b0);
    do_op("div_100_7", DIV,  32'd100,        32'd7,          DIV_LAT, 32'd14,       32'd2,        1'b0);
    do_op("div_by0",   DIV,  32'd7,          32'd0,          2,       32'hFFFFFFFF, 32'd7,        1'b1);
    do_op("add_clr",   ADD,  32'd1,          32'd1,          2,       32'd2,        32'd0,        1'b0);

    // Start pulsed mid-MUL must be ignored; results hold until the MUL completes
    lat = 0;
    @(posedge clk); #1;
    start = 1'b1; op = MUL; in_a = 32'd6; in_b = 32'd7;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 5) begin
        start = 1'b1; op = ADD; in_a = 32'd1; in_b = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c == 5) begin
        chk("ign.busy5", 64'(busy), 64'd1);
        chk("ign.hold_lo", 64'(result_lo), 64'd2);
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("ign.lat", 64'(lat), 64'(MUL_LAT));
    chk("ign.product", {result_hi, result_lo}, 64'd42);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign.no_second_done", 64'(ndone), 64'd0);
    chk("ign.idle_busy", 64'(busy), 64'd0);
    chk("ign.hold_after", {result_hi, result_lo}, 64'd42);

    do_op("div_by0_b", DIV,  32'd7,          32'd0,          2,       32'hFFFFFFFF, 32'd7,        1'b1);

    // Asynchronous reset in cycle 10 of a DIV clears everything at once
    @(posedge clk); #1;
    start = 1'b1; op = DIV; in_a = 32'd100; in_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("rstmid.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.done", 64'(done), 64'd0);
    chk("rstmid.lo", 64'(result_lo), 64'd0);
    chk("rstmid.hi", 64'(result_hi), 64'd0);
    chk("rstmid.dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rstmid.aborted", 64'(ndone), 64'd0);

    do_op("shra",      SHRA, 32'h80000000,   32'd4,          2,       32'hF8000000, 32'd0,        1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
